mem_access: RTL and testbench

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access_pkg.sv | 35 +++
 rtl/mem_access.sv | 209 ++++++++++++++++++++
 tb/tb_mem_access.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/mem_access_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_pkg
// Shared definitions for the memory-access pipeline stage:
//   - instruction opcode width and the opcode constants the stage decodes
//   - FSM state encoding for mem_access
//   - small decode helpers (memory op / branch op classification)
// -----------------------------------------------------------------------------
package mem_access_pkg;

   localparam int OPCODE_WIDTH = 4;

   typedef logic [OPCODE_WIDTH-1:0] opcode_t;

   localparam opcode_t OP_ADD   = 4'h0;
   localparam opcode_t OP_ADDI  = 4'h1;
   localparam opcode_t OP_SUB   = 4'h2;
   localparam opcode_t OP_LOAD  = 4'h8;
   localparam opcode_t OP_STORE = 4'h9;
   localparam opcode_t OP_BEQ   = 4'hA;
   localparam opcode_t OP_BNE   = 4'hB;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACCESS = 1'b1
   } state_t;

   function automatic logic is_mem_op(input opcode_t op);
      return (op == OP_LOAD) || (op == OP_STORE);
   endfunction

   function automatic logic is_branch_op(input opcode_t op);
      return (op == OP_BEQ) || (op == OP_BNE);
   endfunction

endpackage

// File: rtl/mem_access.sv
// -----------------------------------------------------------------------------
// mem_access
// Memory-access stage of the pipeline. Non-memory instructions pass through in
// one cycle; aligned LOAD/STORE issue a registered request to data memory and
// hold the pipeline until ack or timeout. Misaligned accesses and timeouts are
// reported as single-cycle pulses alongside the writeback valid.
//
// Ports:
//   es_clk, es_rst         clock (rising edge), async active-low reset
//   ms_i_ce                instruction valid from execute
//   ms_i_opcode            instruction opcode
//   ms_i_alu_value         ALU result / effective address
//   ms_i_data_rt           store data
//   ms_i_rd_addr           destination register
//   ms_i_mem_ack           memory completion
//   ms_i_mem_rdata         memory read data (valid with ack)
//   ms_o_mem_req/we/addr/wdata   registered memory request
//   ms_o_wb_data, ms_o_rd_addr, ms_o_regwrite, ms_o_ce   writeback payload
//   ms_o_stall             upstream hold while a memory access is in flight
//   ms_o_misalign          misaligned LOAD/STORE pulse
//   ms_o_bus_err           memory timeout pulse
// -----------------------------------------------------------------------------
module mem_access
   import mem_access_pkg::*;
#(
   parameter int DWIDTH  = 32,
   parameter int AWIDTH  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic                    es_clk,
   input  logic                    es_rst,
   input  logic                    ms_i_ce,
   input  logic [OPCODE_WIDTH-1:0] ms_i_opcode,
   input  logic [DWIDTH-1:0]       ms_i_alu_value,
   input  logic [DWIDTH-1:0]       ms_i_data_rt,
   input  logic [4:0]              ms_i_rd_addr,
   input  logic                    ms_i_mem_ack,
   input  logic [DWIDTH-1:0]       ms_i_mem_rdata,
   output logic                    ms_o_mem_req,
   output logic                    ms_o_mem_we,
   output logic [AWIDTH-1:0]       ms_o_mem_addr,
   output logic [DWIDTH-1:0]       ms_o_mem_wdata,
   output logic [DWIDTH-1:0]       ms_o_wb_data,
   output logic [4:0]              ms_o_rd_addr,
   output logic                    ms_o_regwrite,
   output logic                    ms_o_ce,
   output logic                    ms_o_stall,
   output logic                    ms_o_misalign,
   output logic                    ms_o_bus_err
);

   // Counter must hold 0..TIMEOUT-1; keep at least one bit for TIMEOUT=1.
   localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   opcode_t           op_q, op_d;
   logic [4:0]        rd_cap_q, rd_cap_d;

   logic              req_q, req_d;
   logic              we_q, we_d;
   logic [AWIDTH-1:0] addr_q, addr_d;
   logic [DWIDTH-1:0] wdata_q, wdata_d;
   logic [DWIDTH-1:0] wb_data_q, wb_data_d;
   logic [4:0]        rd_out_q, rd_out_d;
   logic              regwrite_q, regwrite_d;
   logic              ce_q, ce_d;
   logic              misalign_q, misalign_d;
   logic              bus_err_q, bus_err_d;

   logic              misaligned;
   logic              timed_out;

   assign misaligned = (ms_i_alu_value[1:0] != 2'b00);
   assign timed_out  = (cnt_q == CNT_LAST);

   // State register
   always_ff @(posedge es_clk or negedge es_rst) begin
      if (!es_rst) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (ms_i_ce && is_mem_op(ms_i_opcode) && !misaligned) state_d = ST_ACCESS;
         end
         ST_ACCESS: begin
            if (ms_i_mem_ack || timed_out) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Output / datapath next-value logic. Writeback outputs default to zero so
   // ce, misalign and bus_err are one-cycle pulses; the request fields hold.
   always_comb begin
      cnt_d      = cnt_q;
      op_d       = op_q;
      rd_cap_d   = rd_cap_q;
      req_d      = req_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      wb_data_d  = '0;
      rd_out_d   = '0;
      regwrite_d = 1'b0;
      ce_d       = 1'b0;
      misalign_d = 1'b0;
      bus_err_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (ms_i_ce) begin
               if (!is_mem_op(ms_i_opcode)) begin
                  ce_d       = 1'b1;
                  wb_data_d  = ms_i_alu_value;
                  rd_out_d   = ms_i_rd_addr;
                  regwrite_d = !is_branch_op(ms_i_opcode);
               end else if (misaligned) begin
                  ce_d       = 1'b1;
                  misalign_d = 1'b1;
                  rd_out_d   = ms_i_rd_addr;
               end else begin
                  req_d    = 1'b1;
                  we_d     = (ms_i_opcode == OP_STORE);
                  addr_d   = AWIDTH'(ms_i_alu_value);
                  wdata_d  = (ms_i_opcode == OP_STORE) ? ms_i_data_rt : '0;
                  op_d     = ms_i_opcode;
                  rd_cap_d = ms_i_rd_addr;
               end
            end
         end
         ST_ACCESS: begin
            // Ack is checked first so it wins over a coincident timeout.
            if (ms_i_mem_ack || timed_out) begin
               req_d    = 1'b0;
               we_d     = 1'b0;
               addr_d   = '0;
               wdata_d  = '0;
               cnt_d    = '0;
               ce_d     = 1'b1;
               rd_out_d = rd_cap_q;
               if (ms_i_mem_ack) begin
                  if (op_q == OP_LOAD) begin
                     wb_data_d  = ms_i_mem_rdata;
                     regwrite_d = 1'b1;
                  end
               end else begin
                  bus_err_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Registered outputs and captured instruction context
   always_ff @(posedge es_clk or negedge es_rst) begin
      if (!es_rst) begin
         cnt_q      <= '0;
         op_q       <= OP_ADD;
         rd_cap_q   <= '0;
         req_q      <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         wb_data_q  <= '0;
         rd_out_q   <= '0;
         regwrite_q <= 1'b0;
         ce_q       <= 1'b0;
         misalign_q <= 1'b0;
         bus_err_q  <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         op_q       <= op_d;
         rd_cap_q   <= rd_cap_d;
         req_q      <= req_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         wb_data_q  <= wb_data_d;
         rd_out_q   <= rd_out_d;
         regwrite_q <= regwrite_d;
         ce_q       <= ce_d;
         misalign_q <= misalign_d;
         bus_err_q  <= bus_err_d;
      end
   end

   assign ms_o_mem_req   = req_q;
   assign ms_o_mem_we    = we_q;
   assign ms_o_mem_addr  = addr_q;
   assign ms_o_mem_wdata = wdata_q;
   assign ms_o_wb_data   = wb_data_q;
   assign ms_o_rd_addr   = rd_out_q;
   assign ms_o_regwrite  = regwrite_q;
   assign ms_o_ce        = ce_q;
   assign ms_o_misalign  = misalign_q;
   assign ms_o_bus_err   = bus_err_q;
   assign ms_o_stall     = (state_q == ST_ACCESS);

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;
   import mem_access_pkg::*;

   localparam int DW = 32;
   localparam int AW = 32;
   localparam int TO = 16;

   logic          es_clk = 1'b0;
   logic          es_rst = 1'b0;
   logic          ms_i_ce = 1'b0;
   opcode_t       ms_i_opcode = OP_ADD;
   logic [DW-1:0] ms_i_alu_value = '0;
   logic [DW-1:0] ms_i_data_rt = '0;
   logic [4:0]    ms_i_rd_addr = '0;
   logic          ms_i_mem_ack = 1'b0;
   logic [DW-1:0] ms_i_mem_rdata = '0;
   logic          ms_o_mem_req, ms_o_mem_we;
   logic [AW-1:0] ms_o_mem_addr;
   logic [DW-1:0] ms_o_mem_wdata, ms_o_wb_data;
   logic [4:0]    ms_o_rd_addr;
   logic          ms_o_regwrite, ms_o_ce, ms_o_stall, ms_o_misalign, ms_o_bus_err;

   int checks = 0;
   int errors = 0;

   mem_access #(.DWIDTH(DW), .AWIDTH(AW), .TIMEOUT(TO)) dut (
      .es_clk(es_clk), .es_rst(es_rst),
      .ms_i_ce(ms_i_ce), .ms_i_opcode(ms_i_opcode), .ms_i_alu_value(ms_i_alu_value),
      .ms_i_data_rt(ms_i_data_rt), .ms_i_rd_addr(ms_i_rd_addr),
      .ms_i_mem_ack(ms_i_mem_ack), .ms_i_mem_rdata(ms_i_mem_rdata),
      .ms_o_mem_req(ms_o_mem_req), .ms_o_mem_we(ms_o_mem_we), .ms_o_mem_addr(ms_o_mem_addr),
      .ms_o_mem_wdata(ms_o_mem_wdata), .ms_o_wb_data(ms_o_wb_data), .ms_o_rd_addr(ms_o_rd_addr),
      .ms_o_regwrite(ms_o_regwrite), .ms_o_ce(ms_o_ce), .ms_o_stall(ms_o_stall),
      .ms_o_misalign(ms_o_misalign), .ms_o_bus_err(ms_o_bus_err)
   );

   always #5 es_clk = ~es_clk;

   // Advance to just after the next rising edge; inputs change and outputs are sampled here.
   task automatic tick();
      @(posedge es_clk);
      #1;
   endtask

   // One instruction, checked against the behavioural outcome it should have.
   // ack_delay = number of ACCESS cycles before ack is driven (>= TO means never).
   task automatic issue(input opcode_t op, input logic [DW-1:0] alu, input logic [DW-1:0] rt,
                        input logic [4:0] rd, input int ack_delay);
      bit            mem_op, mis, exp_rw, exp_berr;
      int            exp_cycles, cycles;
      logic [DW-1:0] exp_wb, rdata_at_ack;
      mem_op = (op == OP_LOAD) || (op == OP_STORE);
      mis    = mem_op && (alu % 4 != 0);
      ms_i_ce = 1'b1; ms_i_opcode = op; ms_i_alu_value = alu; ms_i_data_rt = rt; ms_i_rd_addr = rd;
      tick();
      ms_i_ce = 1'b0;
      if (!mem_op) begin
         exp_rw = !(op == OP_BEQ || op == OP_BNE);
         checks++; if (ms_o_ce !== 1'b1) begin errors++; $display("FAIL alu_ce got %b exp 1", ms_o_ce); end
         checks++; if (ms_o_wb_data !== alu) begin errors++; $display("FAIL alu_wb got %h exp %h", ms_o_wb_data, alu); end
         checks++; if (ms_o_rd_addr !== rd) begin errors++; $display("FAIL alu_rd got %0d exp %0d", ms_o_rd_addr, rd); end
         checks++; if (ms_o_regwrite !== exp_rw) begin errors++; $display("FAIL alu_regwrite op %h got %b exp %b", op, ms_o_regwrite, exp_rw); end
         checks++; if ({ms_o_stall, ms_o_mem_req} !== 2'b00) begin errors++; $display("FAIL alu_stall_req got %b exp 00", {ms_o_stall, ms_o_mem_req}); end
      end else if (mis) begin
         checks++; if ({ms_o_mem_req, ms_o_ce, ms_o_misalign, ms_o_regwrite, ms_o_stall} !== 5'b01100) begin
            errors++; $display("FAIL misalign_resp req/ce/mis/rw/stall got %b exp 01100", {ms_o_mem_req, ms_o_ce, ms_o_misalign, ms_o_regwrite, ms_o_stall}); end
         tick();
         checks++; if ({ms_o_ce, ms_o_misalign} !== 2'b00) begin errors++; $display("FAIL misalign_pulse ce/mis got %b exp 00", {ms_o_ce, ms_o_misalign}); end
      end else begin
         // Outcome from the protocol rules: ack inside the window completes normally.
         exp_berr   = (ack_delay >= TO);
         exp_cycles = exp_berr ? TO : ack_delay + 1;
         cycles = 0;
         rdata_at_ack = '0;
         while (ms_o_mem_req === 1'b1 && cycles < TO + 4) begin
            checks++; if ({ms_o_stall, ms_o_ce, ms_o_mem_we} !== {2'b10, op == OP_STORE}) begin
               errors++; $display("FAIL access_ctl stall/ce/we got %b exp %b", {ms_o_stall, ms_o_ce, ms_o_mem_we}, {2'b10, op == OP_STORE}); end
            checks++; if (ms_o_mem_addr !== alu || ms_o_mem_wdata !== ((op == OP_STORE) ? rt : '0)) begin
               errors++; $display("FAIL access_hold addr %h wdata %h exp %h %h", ms_o_mem_addr, ms_o_mem_wdata, alu, (op == OP_STORE) ? rt : '0); end
            // Upstream noise while stalled must be ignored.
            ms_i_ce = 1'($urandom_range(0, 1)); ms_i_opcode = OP_ADDI; ms_i_alu_value = $urandom;
            ms_i_mem_rdata = $urandom;
            ms_i_mem_ack = (cycles == ack_delay);
            if (cycles == ack_delay) rdata_at_ack = ms_i_mem_rdata;
            tick();
            cycles++;
         end
         ms_i_ce = 1'b0; ms_i_mem_ack = 1'b0;
         exp_wb = (!exp_berr && op == OP_LOAD) ? rdata_at_ack : '0;
         exp_rw = (!exp_berr && op == OP_LOAD);
         checks++; if (cycles !== exp_cycles) begin errors++; $display("FAIL req_cycles got %0d exp %0d", cycles, exp_cycles); end
         checks++; if ({ms_o_ce, ms_o_bus_err, ms_o_regwrite, ms_o_stall, ms_o_mem_req} !== {1'b1, exp_berr, exp_rw, 2'b00}) begin
            errors++; $display("FAIL done_ctl ce/berr/rw/stall/req got %b exp %b", {ms_o_ce, ms_o_bus_err, ms_o_regwrite, ms_o_stall, ms_o_mem_req}, {1'b1, exp_berr, exp_rw, 2'b00}); end
         checks++; if (ms_o_wb_data !== exp_wb) begin errors++; $display("FAIL done_wb got %h exp %h", ms_o_wb_data, exp_wb); end
         checks++; if (ms_o_rd_addr !== rd && !exp_berr) begin errors++; $display("FAIL done_rd got %0d exp %0d", ms_o_rd_addr, rd); end
         tick();
         checks++; if ({ms_o_ce, ms_o_bus_err, ms_o_stall} !== 3'b000) begin errors++; $display("FAIL done_pulse ce/berr/stall got %b exp 000", {ms_o_ce, ms_o_bus_err, ms_o_stall}); end
      end
   endtask

   task automatic test_reset();
      es_rst = 1'b0;
      #12;
      checks++; if ({ms_o_mem_req, ms_o_mem_we, ms_o_ce, ms_o_regwrite, ms_o_stall, ms_o_misalign, ms_o_bus_err} !== 7'b0) begin
         errors++; $display("FAIL reset_ctl got %b exp 0", {ms_o_mem_req, ms_o_mem_we, ms_o_ce, ms_o_regwrite, ms_o_stall, ms_o_misalign, ms_o_bus_err}); end
      checks++; if ({ms_o_mem_addr, ms_o_mem_wdata, ms_o_wb_data, ms_o_rd_addr} !== '0) begin
         errors++; $display("FAIL reset_data got %h exp 0", {ms_o_mem_addr, ms_o_mem_wdata, ms_o_wb_data, ms_o_rd_addr}); end
      tick();
      es_rst = 1'b1;
      tick();
   endtask

   task automatic test_directed();
      issue(OP_ADDI, 32'h0000_0005, 32'h0, 5'd3, 0);
      issue(OP_LOAD, 32'h0000_0100, 32'h0, 5'd7, 3);
      issue(OP_STORE, 32'h0000_0104, 32'h0000_1234, 5'd0, 2);
      issue(OP_LOAD, 32'h0000_0102, 32'h0, 5'd4, 0);
      issue(OP_STORE, 32'h0000_0201, 32'h55, 5'd1, 0);
      issue(OP_BEQ, 32'h0000_0040, 32'h0, 5'd2, 0);
      issue(OP_BNE, 32'h0000_0044, 32'h0, 5'd2, 0);
      issue(OP_LOAD, 32'h0000_0100, 32'h0, 5'd9, 99);   // no ack: timeout
      issue(OP_LOAD, 32'h0000_0108, 32'h0, 5'd9, TO - 1); // ack on the last window cycle
      issue(OP_STORE, 32'h0000_010C, 32'hCAFE, 5'd9, TO); // ack one cycle too late
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] v;
      for (int i = 0; i < 6; i++) begin
         v = $urandom;
         ms_i_ce = 1'b1; ms_i_opcode = (i % 2 == 0) ? OP_ADD : OP_SUB; ms_i_alu_value = v; ms_i_rd_addr = 5'(i + 10);
         tick();
         checks++; if ({ms_o_ce, ms_o_regwrite} !== 2'b11 || ms_o_wb_data !== v || ms_o_rd_addr !== 5'(i + 10)) begin
            errors++; $display("FAIL b2b_%0d ce/rw %b wb %h rd %0d exp 11 %h %0d", i, {ms_o_ce, ms_o_regwrite}, ms_o_wb_data, ms_o_rd_addr, v, i + 10); end
      end
      ms_i_ce = 1'b0;
      tick();
      checks++; if ({ms_o_ce, ms_o_regwrite} !== 2'b00 || ms_o_wb_data !== '0 || ms_o_rd_addr !== '0) begin
         errors++; $display("FAIL idle_zero ce/rw %b wb %h rd %0d exp 0", {ms_o_ce, ms_o_regwrite}, ms_o_wb_data, ms_o_rd_addr); end
   endtask

   task automatic test_reset_mid_access();
      ms_i_ce = 1'b1; ms_i_opcode = OP_LOAD; ms_i_alu_value = 32'h0000_0300; ms_i_rd_addr = 5'd6;
      tick();
      ms_i_ce = 1'b0;
      tick();
      checks++; if ({ms_o_mem_req, ms_o_stall} !== 2'b11) begin errors++; $display("FAIL pre_reset req/stall got %b exp 11", {ms_o_mem_req, ms_o_stall}); end
      #2 es_rst = 1'b0;
      #1;
      checks++; if ({ms_o_mem_req, ms_o_stall, ms_o_ce} !== 3'b000 || ms_o_mem_addr !== '0) begin
         errors++; $display("FAIL async_reset req/stall/ce %b addr %h exp 000 0", {ms_o_mem_req, ms_o_stall, ms_o_ce}, ms_o_mem_addr); end
      tick();
      es_rst = 1'b1;
      ms_i_mem_ack = 1'b1; ms_i_mem_rdata = 32'hBAD0_BAD0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if ({ms_o_ce, ms_o_regwrite, ms_o_mem_req, ms_o_stall} !== 4'b0000) begin
            errors++; $display("FAIL stray_ack_%0d ce/rw/req/stall got %b exp 0000", i, {ms_o_ce, ms_o_regwrite, ms_o_mem_req, ms_o_stall}); end
      end
      ms_i_mem_ack = 1'b0;
      issue(OP_LOAD, 32'h0000_0400, 32'h0, 5'd8, 1);
   endtask

   task automatic test_random();
      opcode_t       ops[7] = '{OP_ADD, OP_ADDI, OP_SUB, OP_BEQ, OP_BNE, OP_LOAD, OP_STORE};
      opcode_t       op;
      logic [DW-1:0] alu;
      for (int n = 0; n < 60; n++) begin
         op  = ops[$urandom_range(0, 6)];
         alu = $urandom;
         if ((op == OP_LOAD || op == OP_STORE) && $urandom_range(0, 3) != 0) alu[1:0] = 2'b00;
         issue(op, alu, $urandom, 5'($urandom), int'($urandom_range(0, 20)));
         if ($urandom_range(0, 3) == 0) tick();
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_reset_mid_access();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
